// File: rtl/scan_tick_gen.sv
// Programmable period divider driving a multi-phase scan index.
// Emits a tick per period, a square wave, a one-hot phase and a frame pulse.
module scan_tick_gen #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 1000,
    parameter int PHASES      = 4,
    parameter int PH_W        = 2
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              div_load,
    output logic              tick,
    output logic              clkout,
    output logic [PH_W-1:0]   phase,
    output logic [PHASES-1:0] phase_oh,
    output logic              frame,
    output logic              load_pend
);

    logic [DIV_W-1:0] n;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend_val;
    logic [DIV_W-1:0] next_n;
    logic [DIV_W-1:0] next_cnt;
    logic             wrap;

    function automatic logic [DIV_W-1:0] clamp2(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    // A load arriving on the wrap edge itself bypasses the pending register.
    always_comb begin
        wrap   = en && (cnt == n - DIV_W'(1));
        next_n = n;
        if (wrap) begin
            if (div_load)
                next_n = clamp2(div_val);
            else if (load_pend)
                next_n = clamp2(pend_val);
        end
        next_cnt = wrap ? '0 : cnt + DIV_W'(1);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            n         <= DIV_W'(DIV_DEFAULT);
            cnt       <= '0;
            pend_val  <= '0;
            load_pend <= 1'b0;
            phase     <= '0;
            phase_oh  <= PHASES'(1);
            tick      <= 1'b0;
            frame     <= 1'b0;
            clkout    <= 1'b1;
        end else begin
            tick  <= wrap;
            frame <= wrap && (phase == PH_W'(PHASES - 1));
            n     <= next_n;

            if (wrap) begin
                load_pend <= 1'b0;
            end else if (div_load) begin
                pend_val  <= div_val;
                load_pend <= 1'b1;
            end

            if (en) begin
                cnt    <= next_cnt;
                clkout <= (next_cnt < (next_n >> 1));
            end

            // phase and phase_oh advance together so the decode never lags.
            if (wrap) begin
                phase    <= (phase == PH_W'(PHASES - 1)) ? '0 : phase + PH_W'(1);
                phase_oh <= {phase_oh[PHASES-2:0], phase_oh[PHASES-1]};
            end
        end
    end

endmodule

// File: tb/tb_scan_tick_gen.sv
// Self-checking bench for scan_tick_gen: directed scenarios plus random
// stimulus, compared each cycle against an integer reference model.
module tb_scan_tick_gen;

    localparam int DIV_W       = 16;
    localparam int DIV_DEFAULT = 1000;
    localparam int PHASES      = 4;
    localparam int PH_W        = 2;
    localparam int VW          = 4 + PH_W + PHASES;

    logic              clkin = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              div_load = 1'b0;
    logic [DIV_W-1:0]  div_val = '0;
    logic              tick, clkout, frame, load_pend;
    logic [PH_W-1:0]   phase;
    logic [PHASES-1:0] phase_oh;
    logic [VW-1:0]     obs;

    int vectors = 0;
    int errors  = 0;

    // Reference model state, plain integers.
    int m_n, m_cnt, m_pend, m_phase;
    bit m_lp, m_tick, m_frame, m_clk;

    scan_tick_gen #(
        .DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT), .PHASES(PHASES), .PH_W(PH_W)
    ) dut (
        .clkin(clkin), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
        .tick(tick), .clkout(clkout), .phase(phase), .phase_oh(phase_oh),
        .frame(frame), .load_pend(load_pend)
    );

    always #5 clkin = ~clkin;

    assign obs = {tick, clkout, frame, load_pend, phase, phase_oh};

    function automatic logic [VW-1:0] exp_vec();
        return {m_tick, m_clk, m_frame, m_lp, PH_W'(m_phase), PHASES'(1 << m_phase)};
    endfunction

    task automatic model_edge();
        int nn;
        if (rst) begin
            m_n = DIV_DEFAULT; m_cnt = 0; m_pend = 0; m_lp = 0;
            m_phase = 0; m_tick = 0; m_frame = 0; m_clk = 1;
            return;
        end
        m_tick = 0; m_frame = 0;
        if (en && m_cnt == m_n - 1) begin
            nn = div_load ? int'(div_val) : (m_lp ? m_pend : m_n);
            m_n = (nn < 2) ? 2 : nn;
            m_lp = 0; m_cnt = 0; m_tick = 1;
            m_frame = (m_phase == PHASES - 1);
            m_phase = (m_phase + 1) % PHASES;
        end else begin
            if (en) m_cnt++;
            if (div_load) begin m_pend = int'(div_val); m_lp = 1; end
        end
        if (en) m_clk = (m_cnt < m_n / 2);
    endtask

    task automatic cycle();
        @(posedge clkin);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; div_load = 0;
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; div_load = 1; div_val = 16'd7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL reset cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        vectors++;
        if (obs !== 10'b0100_00_0001) begin
            errors++; $display("FAIL reset_values: got %b want %b", obs, 10'b0100_00_0001);
        end
        rst = 0; en = 0; div_load = 0;
    endtask

    task automatic test_defaults();
        int first_tick = -1, highs = 0, frames = 0, frame_at = -1, ticks = 0;
        en = 1;
        for (int i = 1; i <= 4000; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL defaults cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (i <= 1000 && clkout) highs++;
            if (tick) begin ticks++; if (first_tick < 0) first_tick = i; end
            if (frame) begin frames++; frame_at = i; end
        end
        vectors++;
        if (first_tick != 1000) begin
            errors++; $display("FAIL first_tick: got %0d want 1000", first_tick);
        end
        vectors++;
        if (highs != 500) begin
            errors++; $display("FAIL clkout_high: got %0d want 500", highs);
        end
        vectors++;
        if (ticks != 4 || frames != 1 || frame_at != 4000) begin
            errors++;
            $display("FAIL frame: ticks %0d frames %0d at %0d want 4 1 4000", ticks, frames, frame_at);
        end
    endtask

    task automatic test_load_mid();
        int got = -1, gap = -1;
        do_reset(); en = 1;
        for (int i = 1; i <= 300; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL load_mid cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        div_load = 1; div_val = 16'd10;
        cycle();
        div_load = 0;
        for (int i = 1; i <= 1000; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL load_mid wait %0d: got %b want %b", i, obs, exp_vec());
            end
            if (tick) begin got = i; break; end
        end
        vectors++;
        if (got != 699) begin
            errors++; $display("FAIL load_mid_wrap: got %0d want 699", got);
        end
        for (int i = 1; i <= 30; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL load_mid run %0d: got %b want %b", i, obs, exp_vec());
            end
            if (tick) begin gap = i; break; end
        end
        vectors++;
        if (gap != 10) begin
            errors++; $display("FAIL load_mid_period: got %0d want 10", gap);
        end
    endtask

    task automatic test_min_period();
        int got = -1;
        do_reset(); en = 1;
        div_load = 1; div_val = 16'd0;
        cycle();
        div_load = 0;
        for (int i = 1; i <= 1100; i++) begin
            cycle();
            if (tick) begin got = i; break; end
        end
        vectors++;
        if (got != 999) begin
            errors++; $display("FAIL min_wrap: got %0d want 999", got);
        end
        for (int i = 1; i <= 20; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec() || clkout !== (i % 2 == 0) || tick !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL min_period cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_enable_hold();
        int got = -1;
        logic h_clk;
        logic [PH_W-1:0] h_ph;
        do_reset(); en = 1;
        for (int i = 1; i <= 200; i++) cycle();
        h_clk = clkout; h_ph = phase;
        en = 0;
        for (int i = 1; i <= 50; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec() || clkout !== h_clk || phase !== h_ph || tick !== 1'b0) begin
                errors++; $display("FAIL en_hold cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        en = 1;
        for (int i = 1; i <= 1000; i++) begin
            cycle();
            if (tick) begin got = i; break; end
        end
        vectors++;
        if (got + 250 != 1050) begin
            errors++; $display("FAIL en_hold_tick: got %0d want 1050", got + 250);
        end
    endtask

    task automatic test_wrap_load();
        int gap = -1;
        do_reset(); en = 1;
        for (int i = 1; i <= 999; i++) cycle();
        div_load = 1; div_val = 16'd20;
        cycle();
        div_load = 0;
        vectors++;
        if (tick !== 1'b1 || load_pend !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL wrap_load edge: got %b want %b", obs, exp_vec());
        end
        for (int i = 1; i <= 40; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec() || load_pend !== 1'b0) begin
                errors++; $display("FAIL wrap_load cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (tick) begin gap = i; break; end
        end
        vectors++;
        if (gap != 20) begin
            errors++; $display("FAIL wrap_load_period: got %0d want 20", gap);
        end
    endtask

    task automatic test_back_to_back();
        int got = -1, gap = -1;
        do_reset(); en = 1;
        for (int i = 1; i <= 10; i++) cycle();
        div_load = 1; div_val = 16'd5; cycle();
        div_val = 16'd3; cycle();
        div_load = 0;
        for (int i = 1; i <= 1000; i++) begin
            cycle();
            if (tick) begin got = i; break; end
        end
        vectors++;
        if (got != 988) begin
            errors++; $display("FAIL b2b_wrap: got %0d want 988", got);
        end
        for (int i = 1; i <= 10; i++) begin
            cycle();
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL b2b cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (tick) begin gap = i; break; end
        end
        vectors++;
        if (gap != 3) begin
            errors++; $display("FAIL b2b_period: got %0d want 3", gap);
        end
    endtask

    task automatic test_reset_mid();
        int got = -1;
        do_reset(); en = 1;
        for (int i = 1; i <= 2700; i++) begin
            div_load = (i == 2500); div_val = 16'd7;
            cycle();
        end
        div_load = 0;
        vectors++;
        if (phase !== 2'd2 || load_pend !== 1'b1) begin
            errors++; $display("FAIL rst_mid setup: phase %0d pend %b want 2 1", phase, load_pend);
        end
        rst = 1;
        cycle();
        rst = 0;
        vectors++;
        if (obs !== 10'b0100_00_0001 || obs !== exp_vec()) begin
            errors++; $display("FAIL rst_mid values: got %b want %b", obs, 10'b0100_00_0001);
        end
        for (int i = 1; i <= 1100; i++) begin
            cycle();
            if (tick) begin got = i; break; end
        end
        vectors++;
        if (got != 1000) begin
            errors++; $display("FAIL rst_mid_period: got %0d want 1000", got);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 1; i <= 3000; i++) begin
            rst      = ($urandom_range(499) == 0);
            en       = ($urandom_range(9) != 0);
            div_load = ($urandom_range(19) == 0);
            div_val  = DIV_W'($urandom_range(20));
            cycle();
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        rst = 0; en = 0; div_load = 0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_load_mid();
        test_min_period();
        test_enable_hold();
        test_wrap_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/scan_tick_gen.md
SCAN_TICK_GEN -- requirements
Module: scan_tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of period counter and div_val.
REQ-002 SHALL have parameter DIV_DEFAULT, default 1000: period N in clkin cycles after reset.
REQ-003 SHALL have parameter PHASES, default 4, legal range 2..256: number of scan phases.
REQ-004 SHALL have parameter PH_W, default 2, equal to ceil(log2(PHASES)): phase index width.
REQ-005 SHALL have port clkin  input  1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have port en  input  1: count enable.
REQ-008 SHALL have port div_val  input  DIV_W: requested new period.
REQ-009 SHALL have port div_load  input  1: single-cycle load request for div_val.
REQ-010 SHALL have port tick  output  1: one-cycle pulse per completed period.
REQ-011 SHALL have port clkout  output  1: registered square wave, one cycle per period; used as data only, never as a clock.
REQ-012 SHALL have port phase  output  PH_W: current scan index, 0..PHASES-1.
REQ-013 SHALL have port phase_oh  output  PHASES: one-hot decode of phase.
REQ-014 SHALL have port frame  output  1: one-cycle pulse when phase wraps to 0.
REQ-015 SHALL have port load_pend  output  1: a loaded period is waiting for the next boundary.

Function
REQ-016 SHALL hold period register N and counter cnt (DIV_W bits), cnt range 0..N-1.
REQ-017 SHALL, on an edge with en=1 and cnt<N-1, increment cnt by 1.
REQ-018 SHALL, on an edge with en=1 and cnt=N-1 (wrap edge), set cnt to 0, set tick to 1, and advance phase by 1 modulo PHASES.
REQ-019 SHALL set tick to 0 on every edge that is not a wrap edge.
REQ-020 SHALL set frame to 1 on a wrap edge where phase goes from PHASES-1 to 0; otherwise frame SHALL be 0.
REQ-021 SHALL keep phase_oh equal to 1<<phase at all times, both registered together.
REQ-022 SHALL register clkout on the same edge as cnt: value 1 when the new cnt < N>>1, else 0 (N=1000: 500 high, 500 low).
REQ-023 SHALL, on an edge with en=0, hold cnt, phase, phase_oh, and clkout, and drive tick=0 and frame=0.
REQ-024 SHALL, on an edge with div_load=1, capture div_val into a pending register and set load_pend=1.
REQ-025 SHALL overwrite an older pending value with a newer div_load; the last request wins.
REQ-026 SHALL copy the pending value into N only on a wrap edge, then clear load_pend; N SHALL never change mid-period.
REQ-027 SHALL, when div_load=1 on a wrap edge, use that same div_val as N for the period starting there; load_pend SHALL then read 0.
REQ-028 SHALL treat a loaded value of 0 or 1 as 2, so the minimum period is 2 cycles.
REQ-029 SHALL keep a pending load pending while en=0; it SHALL apply at the first wrap edge after en returns to 1.

Reset
REQ-030 SHALL, on an edge with rst=1, set: cnt=0; N=DIV_DEFAULT; phase=0; phase_oh=1; tick=0; frame=0; clkout=1; load_pend=0.
REQ-031 SHALL discard any pending load on reset; rst SHALL take priority over en and div_load.

Verification
REQ-032 SHALL cover: reset release, en=1, defaults -> first tick 1000 cycles after release; clkout 500 high/500 low; phase 1,2,3,0; frame coincides with the 4th tick only.
REQ-033 SHALL cover: div_load with div_val=10 at cnt=300 -> load_pend=1 until the 1000-cycle wrap; ticks then every 10 cycles; clkout 5 high/5 low.
REQ-034 SHALL cover: div_val=0 loaded -> period 2; clkout alternates 1,0 each cycle; tick every 2nd cycle.
REQ-035 SHALL cover: en=0 for 50 cycles at cnt=200 -> cnt, clkout, phase frozen; tick=0; next tick arrives 1050 cycles after period start.
REQ-036 SHALL cover: div_load (div_val=20) on the exact wrap edge -> the next period is 20 cycles and load_pend stays 0.
REQ-037 SHALL cover: rst at phase=2, cnt=700 with a load pending -> all outputs at reset values next cycle; period 1000 (pending value lost).
